// File: rtl/div32_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle and holds the result until the next completion.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend, becomes the quotient as it shifts
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;

  logic             is_signed;
  logic             is_rem;
  logic             sa, sb;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ge;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign is_signed = ~op_q[0];
  assign is_rem    = op_q[1];

  // Shifted remainder is WIDTH+1 bits wide; its top bit is rem_q's msb, which
  // alone guarantees it exceeds any WIDTH-bit divisor.
  assign shifted          = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign {borrow, diff}   = {1'b0, shifted} - {1'b0, div_q};
  assign ge               = rem_q[WIDTH-1] | ~borrow;

  assign sa      = is_signed & dvd_q[WIDTH-1];
  assign sb      = is_signed & div_q[WIDTH-1];
  assign quo_fix = (sign_a_q ^ sign_b_q) ? (~dvd_q + 1'b1) : dvd_q;
  assign rem_fix = sign_a_q ? (~rem_q + 1'b1) : rem_q;

  assign busy = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign out  = out_q;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no
    // path through the case statement can infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    div_d    = div_q;
    rem_d    = rem_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !flush) begin
          op_d    = op;
          dvd_d   = a;
          div_d   = b;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        sign_a_d = sa;
        sign_b_d = sb;
        dvd_d    = sa ? (~dvd_q + 1'b1) : dvd_q;
        div_d    = sb ? (~div_q + 1'b1) : div_q;
        rem_d    = '0;
        cnt_d    = '0;
        if (div_q == '0) begin
          out_d   = is_rem ? dvd_q : '1;
          state_d = S_DONE;
        end else if (is_signed && dvd_q == {1'b1, {(WIDTH-1){1'b0}}} && div_q == '1) begin
          out_d   = is_rem ? '0 : dvd_q;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        rem_d = ge ? diff : shifted;
        dvd_d = {dvd_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        out_d   = is_rem ? rem_fix : quo_fix;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase

    // A pipeline kill abandons the operation without touching the held result.
    if (flush && busy) begin
      state_d = S_IDLE;
      out_d   = out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      dvd_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq: arithmetic, special cases,
// latency and the start/flush/reset handshake.
module tb_div32_seq;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int pass_cnt = 0;
  int total_cnt = 0;

  div32_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  // Raises start in the caller's current cycle (cycle 0) and waits for done,
  // returning the done cycle (-1 on timeout), the result and how many sampled
  // cycles had busy high up to and including the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] res, output int busy_n);
    start  = 1'b1;
    op     = o;
    a      = x;
    b      = y;
    lat    = -1;
    res    = 'x;
    busy_n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        lat = c;
        res = out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'd0)
      $display("FAIL reset_state got busy=%b done=%b out=%h exp 0/0/0", busy, done, out);
    else pass_cnt++;
  endtask

  task automatic test_unsigned();
    int lat, bn;
    logic [31:0] r;
    @(posedge clk); #1;
    do_op(OP_DIVU, 32'd100, 32'd7, lat, r, bn);
    total_cnt++;
    if (lat !== 35 || r !== 32'd14 || bn !== 34)
      $display("FAIL divu_100_7 got lat=%0d out=%h busy=%0d exp lat=35 out=0000000e busy=34", lat, r, bn);
    else pass_cnt++;

    @(posedge clk); #1;
    do_op(OP_REMU, 32'd100, 32'd7, lat, r, bn);
    total_cnt++;
    if (lat !== 35 || r !== 32'd2)
      $display("FAIL remu_100_7 got lat=%0d out=%h exp lat=35 out=00000002", lat, r);
    else pass_cnt++;

    @(posedge clk); #1;
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, lat, r, bn);
    total_cnt++;
    if (r !== 32'hFFFF_FFFF)
      $display("FAIL divu_max_1 got %h exp ffffffff", r);
    else pass_cnt++;

    @(posedge clk); #1;
    do_op(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, lat, r, bn);
    total_cnt++;
    if (r !== 32'h7FFF_FFFE)
      $display("FAIL remu_big_divisor got %h exp 7ffffffe", r);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    int lat, bn;
    logic [31:0] r;
    @(posedge clk); #1;
    do_op(OP_DIV, -32'sd7, 32'd2, lat, r, bn);
    total_cnt++;
    if (r !== 32'hFFFF_FFFD) $display("FAIL div_m7_2 got %h exp fffffffd", r);
    else pass_cnt++;

    @(posedge clk); #1;
    do_op(OP_REM, -32'sd7, 32'd2, lat, r, bn);
    total_cnt++;
    if (r !== 32'hFFFF_FFFF) $display("FAIL rem_m7_2 got %h exp ffffffff", r);
    else pass_cnt++;

    @(posedge clk); #1;
    do_op(OP_REM, 32'd7, -32'sd2, lat, r, bn);
    total_cnt++;
    if (r !== 32'd1) $display("FAIL rem_7_m2 got %h exp 00000001", r);
    else pass_cnt++;

    @(posedge clk); #1;
    do_op(OP_DIV, -32'sd8, -32'sd2, lat, r, bn);
    total_cnt++;
    if (r !== 32'd4 || lat !== 35) $display("FAIL div_m8_m2 got out=%h lat=%0d exp 00000004 lat=35", r, lat);
    else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int lat, bn;
    logic [31:0] r;
    @(posedge clk); #1;
    do_op(OP_DIVU, 32'd5, 32'd0, lat, r, bn);
    total_cnt++;
    if (r !== 32'hFFFF_FFFF || lat !== 2 || bn !== 1)
      $display("FAIL divu_5_0 got out=%h lat=%0d busy=%0d exp ffffffff lat=2 busy=1", r, lat, bn);
    else pass_cnt++;

    @(posedge clk); #1;
    do_op(OP_REM, 32'd5, 32'd0, lat, r, bn);
    total_cnt++;
    if (r !== 32'd5 || lat !== 2) $display("FAIL rem_5_0 got out=%h lat=%0d exp 00000005 lat=2", r, lat);
    else pass_cnt++;

    @(posedge clk); #1;
    do_op(OP_DIV, -32'sd5, 32'd0, lat, r, bn);
    total_cnt++;
    if (r !== 32'hFFFF_FFFF || lat !== 2) $display("FAIL div_m5_0 got out=%h lat=%0d exp ffffffff lat=2", r, lat);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int lat, bn;
    logic [31:0] r;
    @(posedge clk); #1;
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, bn);
    total_cnt++;
    if (r !== 32'h8000_0000 || lat !== 2) $display("FAIL div_ovf got out=%h lat=%0d exp 80000000 lat=2", r, lat);
    else pass_cnt++;

    @(posedge clk); #1;
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, bn);
    total_cnt++;
    if (r !== 32'd0 || lat !== 2) $display("FAIL rem_ovf got out=%h lat=%0d exp 00000000 lat=2", r, lat);
    else pass_cnt++;

    @(posedge clk); #1;
    do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, bn);
    total_cnt++;
    if (r !== 32'd0 || lat !== 35) $display("FAIL divu_ovf_operands got out=%h lat=%0d exp 00000000 lat=35", r, lat);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int lat = -1;
    logic [31:0] r = 'x;
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 5) begin a = 32'd1; b = 32'd1; end
      if (c == 10) begin start = 1'b1; op = OP_REMU; a = 32'd50; b = 32'd5; end
      @(negedge clk);
      if (done) begin dones++; lat = c; r = out; end
    end
    total_cnt++;
    if (dones !== 1 || lat !== 35 || r !== 32'd14)
      $display("FAIL ignore_start got dones=%0d lat=%0d out=%h exp 1 35 0000000e", dones, lat, r);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    logic [31:0] r;
    @(posedge clk); #1;
    do_op(OP_DIVU, 32'd100, 32'd7, lat, r, bn);
    do_op(OP_DIV, -32'sd8, -32'sd2, lat, r, bn);
    total_cnt++;
    if (lat !== 35 || r !== 32'd4)
      $display("FAIL back_to_back got lat=%0d out=%h exp lat=35 out=00000004", lat, r);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    int lat, bn;
    int dones = 0;
    logic [31:0] r;
    logic busy11 = 1'bx;
    @(posedge clk); #1;
    do_op(OP_REMU, 32'd100, 32'd7, lat, r, bn);
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 10) flush = 1'b1;
      if (c == 11) flush = 1'b0;
      @(negedge clk);
      if (c == 11) busy11 = busy;
      if (done) dones++;
    end
    total_cnt++;
    if (busy11 !== 1'b0) $display("FAIL flush_busy got %b exp 0", busy11);
    else pass_cnt++;
    total_cnt++;
    if (dones !== 0 || out !== 32'd2)
      $display("FAIL flush_no_done got dones=%0d out=%h exp 0 00000002", dones, out);
    else pass_cnt++;

    // flush alongside a start in IDLE cancels it
    dones = 0;
    start = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd6; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    busy11 = busy;
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
    end
    total_cnt++;
    if (busy11 !== 1'b0 || dones !== 0)
      $display("FAIL flush_cancel_start got busy=%b dones=%0d exp 0 0", busy11, dones);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int lat, bn;
    logic [31:0] r;
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 20) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 32'd0)
      $display("FAIL mid_reset got busy=%b done=%b out=%h exp 0/0/0", busy, done, out);
    else pass_cnt++;

    @(posedge clk); #1;
    do_op(OP_DIVU, 32'd9, 32'd3, lat, r, bn);
    total_cnt++;
    if (lat !== 35 || r !== 32'd3)
      $display("FAIL after_reset_divu got lat=%0d out=%h exp lat=35 out=00000003", lat, r);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Built on repeated subtraction, the inverse of the team's 32-bit ripple adder: one trial subtract per cycle, one quotient bit per cycle.
- Sits beside the ALU in the execute stage and stalls the pipeline through a start/busy/done handshake.
- Result is registered and held until the next completion.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock; one clock, synchronous reset, active-high.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- a  input  WIDTH  dividend; captured on an accepted start.
- b  input  WIDTH  divisor; captured on an accepted start.
- flush  input  1  abort the current operation (pipeline kill).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; out is valid in this cycle.
- out  output  WIDTH  quotient or remainder, held until the next done.

Behaviour:
- Reset: the rst edge forces state=IDLE, busy=0, done=0, out=0, and clears all internal registers. Reset overrides start and flush, including mid-operation.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE/DONE: start=1 captures a, b and op, and moves to PREP; busy=1 from the next cycle. Otherwise DONE returns to IDLE.
- PREP (1 cycle):
  - Signed ops: record sign_a=a[W-1] and sign_b=b[W-1]; replace each operand by its magnitude.
  - Unsigned ops: both signs are 0.
  - Clear the remainder and iteration counter.
  - Detect the special cases and go directly to DONE with out loaded:
    - b==0: quotient = all ones; remainder = a (unmodified).
    - Signed overflow, a==100..0 and b==all ones: quotient = a; remainder = 0.
  - Otherwise go to ITER.
- ITER (exactly WIDTH cycles):
  - rem = {rem[W-2:0], dividend msb}; shift the dividend left.
  - If rem >= divisor: rem = rem - divisor and shift a 1 into the quotient; else shift a 0 into the quotient.
  - The compare uses W+1-bit subtract borrow.
  - Counter 0..W-1; move to FIX after count W-1.
- FIX (1 cycle):
  - Quotient is negated (two's complement) when sign_a != sign_b (signed only).
  - Remainder is negated when sign_a=1.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Register out with the quotient (DIV/DIVU) or remainder (REM/REMU).
  - Move to DONE.
- DONE: done=1 and busy=0 for exactly one cycle. A start in this cycle is accepted (back-to-back).
- Latency, with start sampled in cycle 0:
  - Normal: PREP in cycle 1, ITER in cycles 2..33, FIX in cycle 34, done in cycle 35 (WIDTH+3).
  - Special cases: done in cycle 2.
- start while busy=1 is ignored; operand changes after capture have no effect.
- flush=1 in any busy state returns to IDLE next cycle with busy=0, no done pulse, and out unchanged. flush in IDLE/DONE has no effect except cancelling a simultaneous start; flush wins over start.
- done is never asserted without a preceding accepted start. out changes only on the cycle done rises, or on reset.

Test Plan:
- DIVU a=100, b=7, start in cycle 0 -> busy cycles 1-34, done in cycle 35, out=14. REMU with the same operands -> out=2. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Signed rounding:
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
  - REM 7/-2 -> 1.
  - DIV -8/-2 -> 4.
- Divide by zero:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV -5/0 -> 0xFFFFFFFF.
  - Each with done in cycle 2.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, done in cycle 2. DIVU with the same operands -> 0 after the full 35 cycles.
- Handshake:
  - Second start in cycle 10 is ignored and gives a single done.
  - start in the done cycle launches the next op, with its done 35 cycles later.
  - flush in cycle 10 -> busy=0 in cycle 11, no done, out keeps its previous value.
- rst=1 in cycle 20 of an operation -> busy=0, done=0 and out=0 next cycle. A following DIVU 9/3 -> 3 with nominal latency.
